data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_pkg.sv | 11 +
 rtl/data_mem_responder_latency_counter.sv | 28 ++
 rtl/data_mem_responder.sv | 126 ++++++++++++
 tb/tb_data_mem_responder.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared widths and FSM state type for the data memory responder.
package data_mem_pkg;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned LAT_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;
endpackage

// File: rtl/data_mem_responder_latency_counter.sv
// Wait-state down-counter: loads the configured latency on request acceptance,
// decrements while waiting, and flags the final wait cycle.
module latency_counter
  import data_mem_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [LAT_W-1:0] load_val,
  input  logic             dec,
  output logic             last
);

  logic [LAT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec) begin
      count <= count - LAT_W'(1);
    end
  end

  assign last = (count == LAT_W'(1));

endmodule

// File: rtl/data_mem_responder.sv
// Wait-stated word memory responder with a single-cycle completion pulse.
// Optional misalignment reporting is enabled by defining DATA_MEM_ALIGN_CHECK_EN.
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int unsigned WORDS   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] memAdr,
  input  logic [WORD_W-1:0] memWriteData,
  input  logic              memRead,
  input  logic              memWrite,
  output logic [WORD_W-1:0] memReadData,
  output logic              memReady,
  output logic              memErr
);

  localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  state_t state, state_nx;

  logic [WORD_W-1:0] mem [WORDS];

  logic [WORD_W-1:0] lat_adr;
  logic [WORD_W-1:0] lat_data;
  logic              lat_write;

  logic              accept;
  logic              enter_resp;
  logic              cnt_last;

  logic [WORD_W-1:0] op_adr;
  logic [WORD_W-1:0] op_data;
  logic              op_write;
  logic [IDX_W-1:0]  op_idx;
  logic              op_misalign;
  logic              lat_misalign;
  logic              unused_adr;

  latency_counter u_latency_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (LAT_W'(LATENCY)),
    .dec      (state == WAIT),
    .last     (cnt_last)
  );

  always_comb begin
    state_nx   = state;
    accept     = 1'b0;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        if (memRead || memWrite) begin
          accept = 1'b1;
          if (LATENCY == 0) begin
            state_nx   = RESP;
            enter_resp = 1'b1;
          end else begin
            state_nx = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_last) begin
          state_nx   = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // With zero latency, RESP is entered on the accepting edge itself, so the
  // operation must come straight from the inputs rather than the latches.
  assign op_adr   = (state == IDLE) ? memAdr       : lat_adr;
  assign op_data  = (state == IDLE) ? memWriteData : lat_data;
  assign op_write = (state == IDLE) ? memWrite     : lat_write;
  assign op_idx   = op_adr[IDX_W+1:2];

`ifdef DATA_MEM_ALIGN_CHECK_EN
  assign op_misalign  = (op_adr[1:0] != 2'b00);
  assign lat_misalign = (lat_adr[1:0] != 2'b00);
`else
  assign op_misalign  = 1'b0;
  assign lat_misalign = 1'b0;
`endif

  assign unused_adr = ^{op_adr[WORD_W-1:IDX_W+2], op_adr[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      lat_adr     <= '0;
      lat_data    <= '0;
      lat_write   <= 1'b0;
      memReady    <= 1'b0;
      memErr      <= 1'b0;
      memReadData <= '0;
    end else begin
      state    <= state_nx;
      memReady <= (state == RESP);
      memErr   <= (state == RESP) && lat_misalign;
      if (accept) begin
        lat_adr   <= memAdr;
        lat_data  <= memWriteData;
        lat_write <= memWrite;
      end
      if (enter_resp && !op_write && !op_misalign) begin
        memReadData <= mem[op_idx];
      end
    end
  end

  // The array is never reset; the rst gate keeps an aborted request from committing.
  always_ff @(posedge clk) begin
    if (!rst && enter_resp && op_write && !op_misalign) begin
      mem[op_idx] <= op_data;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: default-latency responder plus a zero-latency instance.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] adr_a, wd_a, rdata_a, adr_b, wd_b, rdata_b;
  logic        rd_a, wr_a, rdy_a, err_a, rd_b, wr_b, rdy_b, err_b;

  int passed = 0;
  int total  = 0;
  logic last_err;
  logic [31:0] last_rdata;

  always #5 clk = ~clk;

  data_mem_responder #(.WORDS(1024), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .memAdr(adr_a), .memWriteData(wd_a),
    .memRead(rd_a), .memWrite(wr_a), .memReadData(rdata_a),
    .memReady(rdy_a), .memErr(err_a)
  );

  data_mem_responder #(.WORDS(1024), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .memAdr(adr_b), .memWriteData(wd_b),
    .memRead(rd_b), .memWrite(wr_b), .memReadData(rdata_b),
    .memReady(rdy_b), .memErr(err_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic drive(input bit b, input logic rd, input logic wr,
                       input logic [31:0] adr, input logic [31:0] wd);
    if (b) begin rd_b = rd; wr_b = wr; adr_b = adr; wd_b = wd; end
    else   begin rd_a = rd; wr_a = wr; adr_a = adr; wd_a = wd; end
  endtask

  // Called at a negedge; checks memReady arrives exp_i negedges after acceptance
  // and lasts exactly one cycle.
  task automatic xact(input bit b, input logic rd, input logic wr,
                      input logic [31:0] adr, input logic [31:0] wd,
                      input int exp_i, input string tag);
    int n = 0;
    bit found = 0;
    drive(b, rd, wr, adr, wd);
    while (!found && n < 20) begin
      @(negedge clk);
      if ((b ? rdy_b : rdy_a) === 1'b1) found = 1;
      else n++;
    end
    chk({tag, "_lat"}, found ? n : -1, exp_i);
    last_err   = b ? err_b : err_a;
    last_rdata = b ? rdata_b : rdata_a;
    drive(b, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk({tag, "_pulse"}, {31'b0, b ? rdy_b : rdy_a}, 32'h0);
  endtask

  initial begin
    int n;
    int first_i;
    int second_i;
    int seen;

    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'b0, rdy_a}, 32'h0);
    chk("rst_err", {31'b0, err_a}, 32'h0);
    chk("rst_rdata", rdata_a, 32'h0);
    chk("rst_ready0", {31'b0, rdy_b}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Default latency: memReady in cycle after accept edge + 3.
    xact(1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3, "wr10");
    chk("wr10_err", {31'b0, last_err}, 32'h0);
    xact(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 3, "rd10");
    chk("rd10_data", last_rdata, 32'hDEADBEEF);
    xact(1'b0, 1'b0, 1'b1, 32'h20, 32'h00001234, 3, "wr20");
    chk("wr20_hold", last_rdata, 32'hDEADBEEF);
    chk("wr20_hold2", rdata_a, 32'hDEADBEEF);

    // Word index wraps modulo WORDS.
    xact(1'b0, 1'b0, 1'b1, 32'h1000, 32'h000000A5, 3, "wr1000");
    xact(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 3, "rd0");
    chk("wrap_data", last_rdata, 32'h000000A5);

    // Inputs changed during WAIT must be ignored.
    drive(1'b0, 1'b0, 1'b1, 32'h20, 32'hCAFE0000);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 32'h24, 32'h00000BAD);
    n = 1;
    seen = 0;
    while (seen == 0 && n < 20) begin
      @(negedge clk);
      if (rdy_a === 1'b1) seen = 1;
      else n++;
    end
    chk("ign_lat", seen ? n : -1, 3);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    xact(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 3, "rd20");
    chk("ign_data", last_rdata, 32'hCAFE0000);

    // Reset while in WAIT aborts the write.
    xact(1'b0, 1'b0, 1'b1, 32'h8, 32'h11111111, 3, "wr8");
    drive(1'b0, 1'b0, 1'b1, 32'h8, 32'h00000001);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("abort_rdata", rdata_a, 32'h0);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rdy_a === 1'b1) seen++;
    end
    chk("abort_noready", seen, 0);
    xact(1'b0, 1'b1, 1'b0, 32'h8, 32'h0, 3, "rd8");
    chk("abort_data", last_rdata, 32'h11111111);

    // Misaligned write.
    xact(1'b0, 1'b0, 1'b1, 32'h4, 32'h00000044, 3, "wr4");
    xact(1'b0, 1'b0, 1'b1, 32'h6, 32'h00000077, 3, "wr6");
    xact(1'b0, 1'b1, 1'b0, 32'h4, 32'h0, 3, "rd4");
`ifdef DATA_MEM_ALIGN_CHECK_EN
    chk("mis_data", last_rdata, 32'h00000044);
`else
    chk("mis_data", last_rdata, 32'h00000077);
`endif
    drive(1'b0, 1'b0, 1'b1, 32'h6, 32'h00000099);
    n = 0;
    seen = 0;
    while (seen == 0 && n < 20) begin
      @(negedge clk);
      if (rdy_a === 1'b1) seen = 1;
      else n++;
    end
    last_err = err_a;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
`ifdef DATA_MEM_ALIGN_CHECK_EN
    chk("mis_err", {31'b0, last_err}, 32'h1);
`else
    chk("mis_err", {31'b0, last_err}, 32'h0);
`endif

    // Held read: one completion every LATENCY+2 cycles.
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    first_i = -1;
    second_i = -1;
    for (int i = 0; i < 30 && second_i < 0; i++) begin
      @(negedge clk);
      if (rdy_a === 1'b1) begin
        if (first_i < 0) first_i = i;
        else second_i = i;
      end
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("b2b_first", first_i, 3);
    chk("b2b_gap", second_i - first_i, 4);
    chk("b2b_data", rdata_a, 32'hDEADBEEF);
    @(negedge clk);

    // Zero latency: read+write treated as write, ready in the next cycle.
    xact(1'b1, 1'b1, 1'b1, 32'h4, 32'h00000005, 1, "l0_rw");
    chk("l0_rw_rdata", last_rdata, 32'h0);
    xact(1'b1, 1'b1, 1'b0, 32'h4, 32'h0, 1, "l0_rd");
    chk("l0_rd_data", last_rdata, 32'h00000005);
    chk("l0_err", {31'b0, err_b}, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
